seq_restoring_div: RTL and testbench

Multi-cycle unsigned integer divider that produces quotient and remainder by restoring shift-subtract, one quotient bit per clock. It is the inverse of the MAC datapath's radix-4 multiplier and ripple-carry adder: the MAC multiplies and accumulates, and this block divides an accumulated or scaled value back down. It uses a single (WIDTH+1)-bit subtractor iterated over WIDTH cycles, trading latency for area in the same style as the rest of the arithmetic units.

---
 rtl/seq_restoring_div.sv | 116 +++++++++++
 tb/tb_seq_restoring_div.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_div.sv
// seq_restoring_div
// Multi-cycle unsigned divider using restoring shift-subtract. It produces one
// quotient bit per clock with a single (WIDTH+1)-bit subtractor, so a division
// takes WIDTH cycles from the accepting edge to the done pulse.
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   start        division request, honoured only while busy=0 (IDLE or DONE)
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while iterating; start is ignored then
//   done         one-cycle pulse; results are valid from this cycle
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  set with done when the captured divisor was zero
module seq_restoring_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   pr;        // partial remainder
  logic [WIDTH-1:0] q;         // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] d;         // captured divisor
  logic [CW-1:0]    cnt;       // iteration index 0..WIDTH-1

  logic             accept;
  logic             last;
  logic [WIDTH:0]   s, t, pr_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             restore;

  // DONE behaves like IDLE for new requests so operations can run back to back.
  assign accept = start && (state != CALC);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == CALC);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: bring the next dividend bit into the partial
  // remainder, trial-subtract the divisor, and keep the difference only if it
  // did not borrow. The borrow is the MSB of the (WIDTH+1)-bit difference.
  always_comb begin
    s       = (pr << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    t       = s - {1'b0, d};
    restore = t[WIDTH];
    pr_nxt  = restore ? s : t;
    q_nxt   = {q[WIDTH-2:0], ~restore};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr          <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      pr  <= '0;
      q   <= dividend;
      d   <= divisor;
      cnt <= '0;
      // Zero divisor skips iteration entirely and reports the saturated result.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      pr  <= pr_nxt;
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      // Results are published straight from the last step's next values so the
      // outputs change exactly on the completion edge.
      if (last) begin
        quotient    <= q_nxt;
        remainder   <= pr_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
        cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
module tb_seq_restoring_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bz8, dn8, zz8;
  logic [7:0]  q8, r8;

  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bz16, dn16, zz16;
  logic [15:0] q16, r16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_restoring_div #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .dividend(a8), .divisor(b8),
    .busy(bz8), .done(dn8), .quotient(q8), .remainder(r8), .div_by_zero(zz8)
  );

  seq_restoring_div #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .dividend(a16), .divisor(b16),
    .busy(bz16), .done(dn16), .quotient(q16), .remainder(r16), .div_by_zero(zz16)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 division and wait (bounded) for done. lat counts edges
  // from the accepting edge to the edge raising done; -1 on timeout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output bit busy_bad);
    a8 = a; b8 = b; s8 = 1'b1;
    cyc;
    s8 = 1'b0;
    lat = 0; busy_bad = 1'b0;
    while (!dn8 && lat < 40) begin
      if (!bz8) busy_bad = 1'b1;
      cyc;
      lat++;
    end
    if (!dn8) lat = -1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat);
    a16 = a; b16 = b; s16 = 1'b1;
    cyc;
    s16 = 1'b0;
    lat = 0;
    while (!dn16 && lat < 40) begin
      cyc;
      lat++;
    end
    if (!dn16) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    tests++; if ({bz8, dn8, zz8, q8, r8} !== 19'd0) begin fails++;
      $display("FAIL reset8 got busy=%0d done=%0d dbz=%0d q=%0d r=%0d exp all 0", bz8, dn8, zz8, q8, r8); end
    tests++; if ({bz16, dn16, zz16, q16, r16} !== 35'd0) begin fails++;
      $display("FAIL reset16 got busy=%0d done=%0d dbz=%0d q=%0d r=%0d exp all 0", bz16, dn16, zz16, q16, r16); end
    rst = 1'b0;
    cyc;
  endtask

  task automatic test_basic;
    int lat; bit bb;
    run8(8'd100, 8'd7, lat, bb);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency got %0d exp 8", lat); end
    tests++; if (bb !== 1'b0) begin fails++; $display("FAIL basic_busy_low_early got 1 exp 0"); end
    tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %0d exp 0", bz8); end
    tests++; if (q8 !== 8'd14) begin fails++; $display("FAIL basic_q got %0d exp 14", q8); end
    tests++; if (r8 !== 8'd2) begin fails++; $display("FAIL basic_r got %0d exp 2", r8); end
    tests++; if (zz8 !== 1'b0) begin fails++; $display("FAIL basic_dbz got %0d exp 0", zz8); end
    cyc;
    tests++; if (dn8 !== 1'b0) begin fails++; $display("FAIL basic_done_one_cycle got %0d exp 0", dn8); end
  endtask

  task automatic test_boundary;
    int ta[5] = '{255, 5, 255, 0, 128};
    int tb[5] = '{1, 9, 255, 13, 2};
    int eq[5] = '{255, 0, 1, 0, 64};
    int er[5] = '{0, 5, 0, 0, 0};
    int lat; bit bb;
    for (int i = 0; i < 5; i++) begin
      run8(8'(ta[i]), 8'(tb[i]), lat, bb);
      tests++; if (lat !== 8 || bb) begin fails++;
        $display("FAIL bound_timing %0d/%0d got lat=%0d busy_bad=%0d exp 8/0", ta[i], tb[i], lat, bb); end
      tests++; if (q8 !== 8'(eq[i]) || r8 !== 8'(er[i]) || zz8 !== 1'b0) begin fails++;
        $display("FAIL bound_result %0d/%0d got q=%0d r=%0d dbz=%0d exp q=%0d r=%0d dbz=0",
                 ta[i], tb[i], q8, r8, zz8, eq[i], er[i]); end
      cyc;
    end
  endtask

  task automatic test_zero_divide;
    int lat; bit bb;
    run8(8'd37, 8'd0, lat, bb);
    tests++; if (lat !== 0) begin fails++; $display("FAIL zero_latency got %0d exp 0", lat); end
    tests++; if (q8 !== 8'hFF || r8 !== 8'd37 || zz8 !== 1'b1) begin fails++;
      $display("FAIL zero_result got q=%0d r=%0d dbz=%0d exp q=255 r=37 dbz=1", q8, r8, zz8); end
    tests++; if (bz8 !== 1'b0) begin fails++; $display("FAIL zero_busy got %0d exp 0", bz8); end
    cyc;
    tests++; if (bz8 !== 1'b0 || dn8 !== 1'b0) begin fails++;
      $display("FAIL zero_after got busy=%0d done=%0d exp 0/0", bz8, dn8); end
    run8(8'd9, 8'd3, lat, bb);
    tests++; if (lat !== 8 || q8 !== 8'd3 || r8 !== 8'd0 || zz8 !== 1'b0) begin fails++;
      $display("FAIL zero_recover got lat=%0d q=%0d r=%0d dbz=%0d exp 8/3/0/0", lat, q8, r8, zz8); end
    cyc;
  endtask

  task automatic test_ignore_start;
    int nd = 0;
    int first = -1;
    logic [7:0] gq = '0, gr = '0;
    a8 = 8'd200; b8 = 8'd9; s8 = 1'b1;
    cyc;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin s8 = 1'b1; a8 = 8'd50; b8 = 8'd5; end
      else s8 = 1'b0;
      cyc;
      if (dn8) begin
        nd++;
        if (first < 0) begin first = k; gq = q8; gr = r8; end
      end
    end
    s8 = 1'b0;
    tests++; if (nd !== 1) begin fails++; $display("FAIL ignore_done_count got %0d exp 1", nd); end
    tests++; if (first !== 8) begin fails++; $display("FAIL ignore_latency got %0d exp 8", first); end
    tests++; if (gq !== 8'd22 || gr !== 8'd2) begin fails++;
      $display("FAIL ignore_result got q=%0d r=%0d exp 22 r2", gq, gr); end
  endtask

  task automatic test_back_to_back;
    int w = 0;
    int lat = 0;
    bit hold_bad = 1'b0;
    a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
    cyc;
    s8 = 1'b0;
    while (!dn8 && w < 40) begin cyc; w++; end
    tests++; if (dn8 !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %0d exp 1", dn8); end
    a8 = 8'd60; b8 = 8'd6; s8 = 1'b1;
    cyc;
    s8 = 1'b0;
    tests++; if (bz8 !== 1'b1 || dn8 !== 1'b0) begin fails++;
      $display("FAIL b2b_accept got busy=%0d done=%0d exp 1/0", bz8, dn8); end
    while (!dn8 && lat < 40) begin
      if (q8 !== 8'd14 || r8 !== 8'd2) hold_bad = 1'b1;
      cyc;
      lat++;
    end
    tests++; if (hold_bad) begin fails++; $display("FAIL b2b_hold got 1 exp 0 (prior 14 r2 not held)"); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_latency got %0d exp 8", lat); end
    tests++; if (q8 !== 8'd10 || r8 !== 8'd0 || zz8 !== 1'b0) begin fails++;
      $display("FAIL b2b_result got q=%0d r=%0d dbz=%0d exp 10 r0 dbz0", q8, r8, zz8); end
    cyc;
  endtask

  task automatic test_reset_mid;
    bit saw = 1'b0;
    int lat; bit bb;
    a8 = 8'd77; b8 = 8'd5; s8 = 1'b1;
    cyc;
    s8 = 1'b0;
    cyc; cyc; cyc;
    #2 rst = 1'b1;
    #1;
    tests++; if ({bz8, dn8, zz8, q8, r8} !== 19'd0) begin fails++;
      $display("FAIL rstmid_clear got busy=%0d done=%0d dbz=%0d q=%0d r=%0d exp all 0", bz8, dn8, zz8, q8, r8); end
    #1 rst = 1'b0;
    repeat (12) begin cyc; if (dn8 || bz8) saw = 1'b1; end
    tests++; if (saw) begin fails++; $display("FAIL rstmid_no_done got activity exp none"); end
    run8(8'd77, 8'd5, lat, bb);
    tests++; if (lat !== 8 || q8 !== 8'd15 || r8 !== 8'd2 || zz8 !== 1'b0) begin fails++;
      $display("FAIL rstmid_fresh got lat=%0d q=%0d r=%0d dbz=%0d exp 8/15/2/0", lat, q8, r8, zz8); end
    cyc;
  endtask

  task automatic test_random;
    logic [15:0] a, b, eq, er;
    logic        ez;
    int          elat, lat;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 16'($urandom_range(32'(a), 65535));
        2:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      if (b == '0) begin eq = 16'hFFFF; er = a; ez = 1'b1; elat = 0; end
      else begin eq = a / b; er = a % b; ez = 1'b0; elat = 16; end
      run16(a, b, lat);
      tests++; if (lat !== elat) begin fails++;
        $display("FAIL rand_latency %0d/%0d got %0d exp %0d", a, b, lat, elat); end
      tests++; if (q16 !== eq || r16 !== er || zz16 !== ez) begin fails++;
        $display("FAIL rand_result %0d/%0d got q=%0d r=%0d dbz=%0d exp q=%0d r=%0d dbz=%0d",
                 a, b, q16, r16, zz16, eq, er, ez); end
      if (!ez) begin
        tests++; if ((32'(q16) * 32'(b) + 32'(r16)) !== 32'(a) || !(r16 < b)) begin fails++;
          $display("FAIL rand_invariant %0d/%0d got q=%0d r=%0d exp q*d+r=a, r<d", a, b, q16, r16); end
      end
      if ($urandom_range(0, 1) == 0) cyc;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_zero_divide;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
